dds_status_tx: RTL and testbench

//  Transmit-side companion to the command parser. On a report request, snapshots the live DDS

---
 rtl/dds_status_tx.sv | 117 +++++++++++
 tb/tb_dds_status_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dds_status_tx.sv
// Status reporter: on req, snapshots the DDS tuning word/enable and sends a 7-byte
// frame (sync, m[31:0] MSB first, en, XOR checksum) through a byte-wide UART handshake.
module dds_status_tx #(
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         START_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] m,
  input  logic        en,
  input  logic        is_transmitting,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, DONE, ABORT} state_t;

  typedef struct packed {
    logic [31:0] m;
    logic        en;
  } snap_t;

  state_t        state, state_nxt;
  snap_t         snap;
  logic [2:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          load, strobe;
  logic [7:0]    cur_byte, csum;

  // Checksum covers everything after the sync byte.
  assign csum = snap.m[31:24] ^ snap.m[23:16] ^ snap.m[15:8] ^ snap.m[7:0] ^ {7'b0, snap.en};

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (idx)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = snap.m[31:24];
      3'd2:    cur_byte = snap.m[23:16];
      3'd3:    cur_byte = snap.m[15:8];
      3'd4:    cur_byte = snap.m[7:0];
      3'd5:    cur_byte = {7'b0, snap.en};
      default: cur_byte = csum;
    endcase
  end

  // State register; transmit/tx_byte are registered so they appear the cycle after SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      snap     <= '0;
      transmit <= 1'b0;
      tx_byte  <= 8'h00;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      transmit <= strobe;
      if (load)   snap    <= '{m: m, en: en};
      if (strobe) tx_byte <= cur_byte;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    load      = 1'b0;
    strobe    = 1'b0;
    case (state)
      IDLE: if (req) begin
        load      = 1'b1;
        idx_nxt   = '0;
        state_nxt = SEND;
      end
      // Never strobe into a UART that is still busy.
      SEND: if (!is_transmitting) begin
        strobe    = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (is_transmitting) begin
          state_nxt = WAIT_LO;
        end else begin
          if (cnt != CW'(START_TIMEOUT)) cnt_nxt = cnt + CW'(1);
          if (cnt >= CW'(START_TIMEOUT - 1)) state_nxt = ABORT;
        end
      end
      WAIT_LO: if (!is_transmitting) begin
        if (idx == 3'd6) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 3'd1;
          state_nxt = SEND;
        end
      end
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == SEND) || (state == WAIT_HI) || (state == WAIT_LO);
    done  = (state == DONE);
    error = (state == ABORT);
  end

endmodule

// File: tb/tb_dds_status_tx.sv
// Directed bench for dds_status_tx: table of frames plus hand-written corner sequences
// (snapshot, ignored req, start timeout, busy UART at acceptance, mid-frame reset).
module tb_dds_status_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] m = '0;
  logic        en = 1'b0;
  logic        is_transmitting;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        busy, done, error;

  always #5 clk = ~clk;

  dds_status_tx dut (
    .clk(clk), .rst_n(rst_n), .req(req), .m(m), .en(en),
    .is_transmitting(is_transmitting), .transmit(transmit), .tx_byte(tx_byte),
    .busy(busy), .done(done), .error(error)
  );

  // UART model: busy for 10 cycles after each strobe when enabled.
  logic       uart_on = 1'b1;
  logic       force_busy = 1'b0;
  logic [7:0] ucnt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n)                 ucnt <= 8'd0;
    else if (uart_on && transmit) ucnt <= 8'd10;
    else if (ucnt != 8'd0)      ucnt <= ucnt - 8'd1;
  assign is_transmitting = force_busy | (ucnt != 8'd0);

  // Monitor
  logic [7:0] cap[$];
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, cyc = 0, strobe_cyc = 0, err_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (transmit) begin
      if (cap.size() == 0) strobe_cyc = cyc;
      cap.push_back(tx_byte);
    end
    if (done) done_cnt++;
    if (error) begin err_cnt++; err_cyc = cyc; end
    if (done && error) both_cnt++;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]      m;
    logic             en;
    logic [6:0][7:0]  exp;   // exp[0] = B0 ... exp[6] = checksum
  } vec_t;
  vec_t vecs[4];

  task automatic clear_mon();
    cap.delete();
    done_cnt = 0; err_cnt = 0; both_cnt = 0;
  endtask

  task automatic start_frame(input logic [31:0] mv, input logic ev);
    @(posedge clk); clear_mon();
    @(negedge clk); m = mv; en = ev; req = 1'b1;
    @(negedge clk); req = 1'b0;
  endtask

  // Waits for done/error; counts cycles where busy dropped early; optional mid-frame req.
  task automatic wait_end(input int pulse_at, output int gap, output bit timed_out);
    gap = 0; timed_out = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      if (done || error) begin timed_out = 1'b0; break; end
      if (!busy) gap++;
      req = (c == pulse_at);
      @(negedge clk);
    end
    req = 1'b0;
  endtask

  task automatic check_frame(input vec_t v, input string tag);
    chk({tag, "_nbytes"}, cap.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("%s_b%0d", tag, i), (cap.size() > i) ? cap[i] : 8'hxx, v.exp[i]);
    @(negedge clk);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_err_cnt"},  err_cnt, 0);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  int gap;
  bit to;

  initial begin
    vecs[0] = '{32'h1234_5678, 1'b1, 56'h09_01_78_56_34_12_A5};
    vecs[1] = '{32'hFFFF_FFFF, 1'b0, 56'h00_00_FF_FF_FF_FF_A5};
    vecs[2] = '{32'hDEAD_BEEF, 1'b1, 56'h23_01_EF_BE_AD_DE_A5};
    vecs[3] = '{32'h0102_0408, 1'b1, 56'h0E_01_08_04_02_01_A5};

    repeat (2) @(negedge clk);
    chk("rst_transmit", transmit, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      start_frame(vecs[v].m, vecs[v].en);
      wait_end(-1, gap, to);
      chk($sformatf("vec%0d_timeout", v), to, 0);
      chk($sformatf("vec%0d_busy_gap", v), gap, 0);
      check_frame(vecs[v], $sformatf("vec%0d", v));
    end

    // Snapshot holds; mid-frame req and req in the done cycle are both ignored.
    start_frame(32'h1234_5678, 1'b1);
    m = 32'h0; en = 1'b0;
    wait_end(30, gap, to);
    chk("snap_timeout", to, 0);
    req = 1'b1;
    check_frame(vecs[0], "snap");
    req = 1'b0;
    repeat (40) @(negedge clk);
    chk("snap_no_second_frame", cap.size(), 7);
    chk("snap_idle_busy", busy, 0);

    // UART never responds: error 16 cycles after the first strobe.
    uart_on = 1'b0;
    start_frame(32'h1234_5678, 1'b1);
    wait_end(-1, gap, to);
    chk("tmo_timeout", to, 0);
    chk("tmo_busy_gap", gap, 0);
    @(negedge clk);
    chk("tmo_err_cnt", err_cnt, 1);
    chk("tmo_done_cnt", done_cnt, 0);
    chk("tmo_latency", err_cyc - strobe_cyc, 16);
    chk("tmo_nbytes", cap.size(), 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_error_pulse", error, 0);
    uart_on = 1'b1;

    // UART busy at acceptance: no strobe until it drops, then strobe next cycle.
    force_busy = 1'b1;
    start_frame(32'hDEAD_BEEF, 1'b1);
    repeat (20) @(negedge clk);
    chk("hold_no_strobe", cap.size(), 0);
    chk("hold_busy", busy, 1);
    force_busy = 1'b0;
    @(negedge clk);
    chk("hold_strobe", transmit, 1);
    chk("hold_byte", tx_byte, 8'hA5);
    wait_end(-1, gap, to);
    chk("hold_timeout", to, 0);
    check_frame(vecs[2], "hold");

    // Reset while B3 is in flight, then a fresh frame.
    start_frame(32'hFFFF_FFFF, 1'b0);
    to = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (cap.size() >= 4) begin to = 1'b0; break; end
      @(posedge clk);
    end
    chk("mrst_reach_b3", to, 0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mrst_transmit", transmit, 0);
    chk("mrst_tx_byte", tx_byte, 8'h00);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_error", error, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mrst_no_pulse", done_cnt + err_cnt, 0);
    chk("mrst_no_more_bytes", cap.size(), 4);
    start_frame(32'hFFFF_FFFF, 1'b0);
    wait_end(-1, gap, to);
    chk("mrst_fresh_timeout", to, 0);
    check_frame(vecs[1], "mrst_fresh");

    chk("done_error_exclusive", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
